// File: rtl/prog_down_counter.sv
// -----------------------------------------------------------------------------
// prog_down_counter
//
// Programmable down-counter / interval timer. A start loads the period and the
// mode, the count then decrements once per enabled clock and flags expiry with
// a one-clock terminal-count pulse. One-shot mode parks in DONE at zero;
// auto-reload mode reloads the captured period and keeps running.
//
// All state is updated on the falling edge of clk; rst clears everything
// asynchronously.
//
// Ports:
//   clk          clock (falling edge active)
//   rst          asynchronous active-high reset
//   start        load period/mode and (re)start counting
//   period       reload value, captured on start only
//   en           count enable, 0 pauses the count in RUN
//   auto_reload  1 = periodic, 0 = one-shot, captured on start only
//   Q            current count value (registered)
//   busy         high while in RUN
//   tc           terminal-count pulse, one clock per expiry
//   done         one-shot completion flag, held until next start or reset
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | out of reset, Q = 0, waiting for start
// RUN   | counting down from the captured period
// DONE  | one-shot expired, Q = 0, done held until the next start
// -----------------------------------------------------------------------------
module prog_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] period,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] period_reg;
    logic             mode_reg;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            Q          <= '0;
            busy       <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
            period_reg <= '0;
            mode_reg   <= 1'b0;
        end else begin
            // tc is a single-clock pulse; only an expiry edge raises it.
            tc <= 1'b0;
            if (start) begin
                // start wins over enable and over a coincident expiry, from
                // any state.
                state      <= RUN;
                Q          <= period;
                period_reg <= period;
                mode_reg   <= auto_reload;
                busy       <= 1'b1;
                done       <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (en) begin
                            if (Q != '0) begin
                                Q <= Q - WIDTH'(1);
                            end else begin
                                tc <= 1'b1;
                                if (mode_reg) begin
                                    Q <= period_reg;
                                end else begin
                                    Q     <= '0;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        Q    <= '0;
                        done <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        Q     <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_down_counter.sv
module tb_prog_down_counter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] period;
    logic       en;
    logic       auto_reload;
    logic [3:0] Q;
    logic       busy;
    logic       tc;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    prog_down_counter #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .period      (period),
        .en          (en),
        .auto_reload (auto_reload),
        .Q           (Q),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] period;
        logic       en;
        logic       ar;
        logic [3:0] q;
        logic       busy;
        logic       tc;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic [3:0] p, input logic e,
                                input logic a, input logic [3:0] q, input logic b,
                                input logic t, input logic d);
        vec_t v;
        v.start = s; v.period = p; v.en = e; v.ar = a;
        v.q = q; v.busy = b; v.tc = t; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] q, input logic b,
                           input logic t, input logic d);
        chk({tag, "_q"},    32'(Q),    32'(q));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_tc"},   32'(tc),   32'(t));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    // Drive inputs, let one active (falling) edge pass, sample 1 time unit later.
    task automatic step(input logic s, input logic [3:0] p, input logic e, input logic a);
        start = s; period = p; en = e; auto_reload = a;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; period = '0; en = 1'b0; auto_reload = 1'b0;

        // {start, period, en, ar} -> {Q, busy, tc, done}
        // IDLE ignores en
        add(0, 4'd7, 1, 0,  4'd0, 0, 0, 0);
        // one-shot, period 5
        add(1, 4'd5, 1, 0,  4'd5, 1, 0, 0);
        add(0, 4'd5, 1, 0,  4'd4, 1, 0, 0);
        add(0, 4'd5, 1, 0,  4'd3, 1, 0, 0);
        add(0, 4'd5, 1, 0,  4'd2, 1, 0, 0);
        add(0, 4'd5, 1, 0,  4'd1, 1, 0, 0);
        add(0, 4'd5, 1, 0,  4'd0, 1, 0, 0);
        add(0, 4'd5, 1, 0,  4'd0, 0, 1, 1);
        add(0, 4'd5, 1, 0,  4'd0, 0, 0, 1);
        add(0, 4'd5, 1, 0,  4'd0, 0, 0, 1);
        // auto-reload, period 3
        add(1, 4'd3, 1, 1,  4'd3, 1, 0, 0);
        add(0, 4'd3, 1, 1,  4'd2, 1, 0, 0);
        add(0, 4'd3, 1, 1,  4'd1, 1, 0, 0);
        add(0, 4'd3, 1, 1,  4'd0, 1, 0, 0);
        add(0, 4'd3, 1, 1,  4'd3, 1, 1, 0);
        add(0, 4'd3, 1, 1,  4'd2, 1, 0, 0);
        add(0, 4'd3, 1, 1,  4'd1, 1, 0, 0);
        add(0, 4'd3, 1, 1,  4'd0, 1, 0, 0);
        add(0, 4'd3, 1, 1,  4'd3, 1, 1, 0);
        add(0, 4'd3, 1, 1,  4'd2, 1, 0, 0);
        // enable gating, one-shot period 4, pause 2 edges at Q=2
        add(1, 4'd4, 1, 0,  4'd4, 1, 0, 0);
        add(0, 4'd4, 1, 0,  4'd3, 1, 0, 0);
        add(0, 4'd4, 1, 0,  4'd2, 1, 0, 0);
        add(0, 4'd4, 0, 0,  4'd2, 1, 0, 0);
        add(0, 4'd4, 0, 0,  4'd2, 1, 0, 0);
        add(0, 4'd4, 1, 0,  4'd1, 1, 0, 0);
        add(0, 4'd4, 1, 0,  4'd0, 1, 0, 0);
        add(0, 4'd4, 1, 0,  4'd0, 0, 1, 1);
        // period/mode changes while busy are ignored until start
        add(1, 4'd2, 1, 1,  4'd2, 1, 0, 0);
        add(0, 4'd12, 1, 0, 4'd1, 1, 0, 0);
        add(0, 4'd12, 1, 0, 4'd0, 1, 0, 0);
        add(0, 4'd12, 1, 0, 4'd2, 1, 1, 0);
        add(1, 4'd9, 1, 0,  4'd9, 1, 0, 0);
        add(0, 4'd9, 1, 0,  4'd8, 1, 0, 0);
        // start coincident with expiry: restart wins
        add(1, 4'd2, 1, 0,  4'd2, 1, 0, 0);
        add(0, 4'd2, 1, 0,  4'd1, 1, 0, 0);
        add(0, 4'd2, 1, 0,  4'd0, 1, 0, 0);
        add(1, 4'd1, 1, 0,  4'd1, 1, 0, 0);
        add(0, 4'd1, 1, 0,  4'd0, 1, 0, 0);
        add(0, 4'd1, 1, 0,  4'd0, 0, 1, 1);
        // period 0, auto-reload
        add(1, 4'd0, 1, 1,  4'd0, 1, 0, 0);
        add(0, 4'd0, 1, 1,  4'd0, 1, 1, 0);
        add(0, 4'd0, 1, 1,  4'd0, 1, 1, 0);
        add(0, 4'd0, 1, 1,  4'd0, 1, 1, 0);
        add(0, 4'd0, 0, 1,  4'd0, 1, 0, 0);
        add(0, 4'd0, 1, 1,  4'd0, 1, 1, 0);
        // period 0, one-shot
        add(1, 4'd0, 1, 0,  4'd0, 1, 0, 0);
        add(0, 4'd0, 1, 0,  4'd0, 0, 1, 1);
        add(0, 4'd0, 1, 0,  4'd0, 0, 0, 1);

        #12;
        chk_all("reset", 4'd0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].period, vecs[i].en, vecs[i].ar);
            chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].tc, vecs[i].done);
        end

        // Reset asserted between edges while counting at Q=5.
        step(1, 4'd8, 1, 0);
        step(0, 4'd8, 1, 0);
        step(0, 4'd8, 1, 0);
        step(0, 4'd8, 1, 0);
        chk_all("pre_rst", 4'd5, 1, 0, 0);
        #3 rst = 1'b1;
        #1 chk_all("rst_mid", 4'd0, 0, 0, 0);
        #2 rst = 1'b0;
        step(0, 4'd8, 1, 0);
        chk_all("idle_after_rst", 4'd0, 0, 0, 0);

        // Reset while tc is high clears it immediately.
        step(1, 4'd0, 1, 1);
        step(0, 4'd0, 1, 1);
        chk_all("pre_rst_tc", 4'd0, 1, 1, 0);
        #3 rst = 1'b1;
        #1 chk_all("rst_tc", 4'd0, 0, 0, 0);
        #2 rst = 1'b0;

        // Reset clears a held done flag.
        step(1, 4'd0, 1, 0);
        step(0, 4'd0, 1, 0);
        step(0, 4'd0, 1, 0);
        chk_all("pre_rst_done", 4'd0, 0, 0, 1);
        #3 rst = 1'b1;
        #1 chk_all("rst_done", 4'd0, 0, 0, 0);
        #2 rst = 1'b0;
        step(0, 4'd0, 0, 0);
        chk_all("idle_final", 4'd0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
